// File: rtl/seq_match_engine.sv
// seq_match_engine: key-sequence game engine.
// Holds a per-level key sequence memory, matches player key presses against
// the current level's sequence, enforces a per-level time limit and tracks
// level, step index and remaining lives.
// Optional build macro SEQ_MATCH_DEBOUNCE_EN inserts a key debouncer in front
// of the matcher; without it key_pressed is used directly.
module seq_match_engine #(
    parameter int KEY_W        = 4,
    parameter int MAX_LEN      = 8,
    parameter int LEVELS       = 4,
    parameter int LIVES        = 3,
    parameter int TIMEOUT      = 1000,
    parameter int DEBOUNCE_CYC = 4,
    localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1,
    localparam int WIDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int IDX_W  = $clog2(MAX_LEN + 1),
    localparam int LIFE_W = $clog2(LIVES + 1),
    localparam int TMR_W  = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [KEY_W-1:0]  key_pressed,
    input  logic              wr_en,
    input  logic [LVL_W-1:0]  wr_level,
    input  logic [WIDX_W-1:0] wr_idx,
    input  logic [KEY_W-1:0]  wr_key,
    output logic [KEY_W-1:0]  expected_key,
    output logic              key_match,
    output logic              key_miss,
    output logic              level_done,
    output logic              lose_life,
    output logic [LIFE_W-1:0] lives,
    output logic [LVL_W-1:0]  level,
    output logic [IDX_W-1:0]  idx,
    output logic [TMR_W-1:0]  timer_left,
    output logic              busy,
    output logic              game_over,
    output logic              game_won
);

    localparam int DEPTH  = LEVELS * MAX_LEN;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [KEY_W-1:0] KEY_ONES = {KEY_W{1'b1}};
    localparam logic [KEY_W-1:0] KEY_NONE = {KEY_W{1'b0}};

    // Parameter sanity: a game needs at least one life, one timer cycle and
    // a debounce window of at least one cycle.
    if (LIVES < 1 || TIMEOUT < 1 || DEBOUNCE_CYC < 1 || LEVELS < 1 || MAX_LEN < 1) begin : g_bad_param
        $error("seq_match_engine: illegal parameter value");
    end

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SCAN     = 4'd1,
        ST_MATCH    = 4'd2,
        ST_MISS     = 4'd3,
        ST_WAIT_REL = 4'd4,
        ST_LVL_DONE = 4'd5,
        ST_FAIL     = 4'd6,
        ST_OVER     = 4'd7,
        ST_WIN      = 4'd8
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [LIFE_W-1:0]   lives_r;
    logic [LIFE_W-1:0]   lives_next_s;
    logic [LVL_W-1:0]    level_r;
    logic [LVL_W-1:0]    level_next_s;
    logic [IDX_W-1:0]    idx_r;
    logic [IDX_W-1:0]    idx_next_s;
    logic [TMR_W-1:0]    timer_r;
    logic [TMR_W-1:0]    timer_next_s;
    logic [TMR_W-1:0]    timer_dec_s;
    logic                key_match_r;
    logic                key_miss_r;
    logic                level_done_r;
    logic                lose_life_r;
    logic                busy_r;
    logic                game_over_r;
    logic                game_won_r;

    logic [KEY_W-1:0]    mem_r [DEPTH];
    logic [ADDR_W-1:0]   wr_addr_s;
    logic                wr_ok_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [KEY_W-1:0]    exp_key_s;
    logic                idle_s;
    logic [KEY_W-1:0]    key_seen_s;

`ifdef SEQ_MATCH_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

    logic [KEY_W-1:0] db_cand_r;
    logic [KEY_W-1:0] db_key_r;
    logic [DB_W-1:0]  db_cnt_r;

    // Debouncer: a new key value is forwarded only after it has been stable
    // for DEBOUNCE_CYC consecutive cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cand_r <= KEY_NONE;
            db_key_r  <= KEY_NONE;
            db_cnt_r  <= {DB_W{1'b0}};
        end else if (key_pressed != db_cand_r) begin
            db_cand_r <= key_pressed;
            db_cnt_r  <= {DB_W{1'b0}};
        end else if (db_cnt_r == DB_W'(DEBOUNCE_CYC - 1)) begin
            db_key_r  <= db_cand_r;
        end else begin
            db_cnt_r  <= db_cnt_r + DB_W'(1);
        end
    end

    assign key_seen_s = db_key_r;
`else
    assign key_seen_s = key_pressed;
`endif

    assign idle_s = (state_r == ST_IDLE) || (state_r == ST_OVER) || (state_r == ST_WIN);

    // Memory address decode for the write port and the combinational read.
    always_comb begin
        wr_addr_s = ADDR_W'(int'(wr_level) * MAX_LEN + int'(wr_idx));
        wr_ok_s   = wr_en && idle_s && (int'(wr_level) < LEVELS) && (int'(wr_idx) < MAX_LEN);
        rd_addr_s = ADDR_W'(int'(level_r) * MAX_LEN + int'(idx_r));
        if (int'(idx_r) < MAX_LEN) begin
            exp_key_s = mem_r[rd_addr_s];
        end else begin
            exp_key_s = KEY_ONES;
        end
    end

    // Sequence memory: resets to terminators, writable only while not playing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= KEY_ONES;
            end
        end else if (wr_ok_s) begin
            mem_r[wr_addr_s] <= wr_key;
        end
    end

    assign timer_dec_s = (timer_r == {TMR_W{1'b0}}) ? {TMR_W{1'b0}} : (timer_r - TMR_W'(1));

    // Next-state and datapath update for the game FSM.
    always_comb begin
        state_next_s = state_r;
        lives_next_s = lives_r;
        level_next_s = level_r;
        idx_next_s   = idx_r;
        timer_next_s = timer_r;
        case (state_r)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (start) begin
                    lives_next_s = LIFE_W'(LIVES);
                    level_next_s = {LVL_W{1'b0}};
                    idx_next_s   = {IDX_W{1'b0}};
                    timer_next_s = TMR_W'(TIMEOUT);
                    state_next_s = ST_SCAN;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_SCAN: begin
                timer_next_s = timer_dec_s;
                if (timer_r == {TMR_W{1'b0}}) begin
                    state_next_s = ST_FAIL;
                end else if (exp_key_s == KEY_ONES) begin
                    state_next_s = ST_LVL_DONE;
                end else if (key_seen_s == exp_key_s) begin
                    state_next_s = ST_MATCH;
                end else if (key_seen_s != KEY_NONE) begin
                    state_next_s = ST_MISS;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end
            ST_MATCH: begin
                timer_next_s = timer_dec_s;
                idx_next_s   = idx_r + IDX_W'(1);
                state_next_s = ST_WAIT_REL;
            end
            ST_MISS: begin
                timer_next_s = timer_dec_s;
                idx_next_s   = {IDX_W{1'b0}};
                state_next_s = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                timer_next_s = timer_dec_s;
                if (timer_r == {TMR_W{1'b0}}) begin
                    state_next_s = ST_FAIL;
                end else if (key_seen_s == KEY_NONE) begin
                    state_next_s = ST_SCAN;
                end else begin
                    state_next_s = ST_WAIT_REL;
                end
            end
            ST_LVL_DONE: begin
                if (level_r == LVL_W'(LEVELS - 1)) begin
                    state_next_s = ST_WIN;
                end else begin
                    level_next_s = level_r + LVL_W'(1);
                    idx_next_s   = {IDX_W{1'b0}};
                    timer_next_s = TMR_W'(TIMEOUT);
                    state_next_s = ST_SCAN;
                end
            end
            ST_FAIL: begin
                lives_next_s = lives_r - LIFE_W'(1);
                idx_next_s   = {IDX_W{1'b0}};
                if (lives_r == LIFE_W'(1)) begin
                    state_next_s = ST_OVER;
                end else begin
                    timer_next_s = TMR_W'(TIMEOUT);
                    state_next_s = ST_SCAN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            lives_r      <= LIFE_W'(LIVES);
            level_r      <= {LVL_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            timer_r      <= {TMR_W{1'b0}};
            key_match_r  <= 1'b0;
            key_miss_r   <= 1'b0;
            level_done_r <= 1'b0;
            lose_life_r  <= 1'b0;
            busy_r       <= 1'b0;
            game_over_r  <= 1'b0;
            game_won_r   <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            lives_r      <= lives_next_s;
            level_r      <= level_next_s;
            idx_r        <= idx_next_s;
            timer_r      <= timer_next_s;
            key_match_r  <= (state_next_s == ST_MATCH);
            key_miss_r   <= (state_next_s == ST_MISS);
            level_done_r <= (state_next_s == ST_LVL_DONE);
            lose_life_r  <= (state_next_s == ST_FAIL);
            busy_r       <= !((state_next_s == ST_IDLE) || (state_next_s == ST_OVER) ||
                              (state_next_s == ST_WIN));
            game_over_r  <= (state_next_s == ST_OVER);
            game_won_r   <= (state_next_s == ST_WIN);
        end
    end

    assign expected_key = exp_key_s;
    assign key_match    = key_match_r;
    assign key_miss     = key_miss_r;
    assign level_done   = level_done_r;
    assign lose_life    = lose_life_r;
    assign lives        = lives_r;
    assign level        = level_r;
    assign idx          = idx_r;
    assign timer_left   = timer_r;
    assign busy         = busy_r;
    assign game_over    = game_over_r;
    assign game_won     = game_won_r;

endmodule

// File: tb/tb_seq_match_engine.sv
// Directed self-checking bench for seq_match_engine.
// dut_a: default geometry with TIMEOUT=50 (match, miss, timeout, busy write).
// dut_b: LIVES=1, TIMEOUT=20, LEVELS=2 (game over, restart, win).
module tb_seq_match_engine;

    logic clk;
    logic reset;

    // dut_a signals
    logic       a_start;
    logic [3:0] a_key;
    logic       a_wr_en;
    logic [1:0] a_wr_level;
    logic [2:0] a_wr_idx;
    logic [3:0] a_wr_key;
    logic [3:0] a_expected_key;
    logic       a_key_match, a_key_miss, a_level_done, a_lose_life;
    logic [1:0] a_lives;
    logic [1:0] a_level;
    logic [3:0] a_idx;
    logic [5:0] a_timer_left;
    logic       a_busy, a_game_over, a_game_won;

    // dut_b signals
    logic       b_start;
    logic [3:0] b_key;
    logic       b_wr_en;
    logic [0:0] b_wr_level;
    logic [2:0] b_wr_idx;
    logic [3:0] b_wr_key;
    logic [3:0] b_expected_key;
    logic       b_key_match, b_key_miss, b_level_done, b_lose_life;
    logic [0:0] b_lives;
    logic [0:0] b_level;
    logic [3:0] b_idx;
    logic [4:0] b_timer_left;
    logic       b_busy, b_game_over, b_game_won;

    int n_checks = 0;
    int n_pass   = 0;

    seq_match_engine #(.TIMEOUT(50)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .key_pressed(a_key),
        .wr_en(a_wr_en), .wr_level(a_wr_level), .wr_idx(a_wr_idx), .wr_key(a_wr_key),
        .expected_key(a_expected_key), .key_match(a_key_match), .key_miss(a_key_miss),
        .level_done(a_level_done), .lose_life(a_lose_life), .lives(a_lives),
        .level(a_level), .idx(a_idx), .timer_left(a_timer_left), .busy(a_busy),
        .game_over(a_game_over), .game_won(a_game_won)
    );

    seq_match_engine #(.LIVES(1), .TIMEOUT(20), .LEVELS(2)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .key_pressed(b_key),
        .wr_en(b_wr_en), .wr_level(b_wr_level), .wr_idx(b_wr_idx), .wr_key(b_wr_key),
        .expected_key(b_expected_key), .key_match(b_key_match), .key_miss(b_key_miss),
        .level_done(b_level_done), .lose_life(b_lose_life), .lives(b_lives),
        .level(b_level), .idx(b_idx), .timer_left(b_timer_left), .busy(b_busy),
        .game_over(b_game_over), .game_won(b_game_won)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic a_write(input logic [1:0] lvl, input logic [2:0] i, input logic [3:0] k);
        a_wr_en = 1'b1; a_wr_level = lvl; a_wr_idx = i; a_wr_key = k;
        tick(1);
        a_wr_en = 1'b0;
    endtask

    task automatic b_write(input logic [0:0] lvl, input logic [2:0] i, input logic [3:0] k);
        b_wr_en = 1'b1; b_wr_level = lvl; b_wr_idx = i; b_wr_key = k;
        tick(1);
        b_wr_en = 1'b0;
    endtask

    task automatic a_go();
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
    endtask

    task automatic b_go();
        b_start = 1'b1;
        tick(1);
        b_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_start = 1'b0; a_key = 4'd0; a_wr_en = 1'b0; a_wr_level = 2'd0; a_wr_idx = 3'd0; a_wr_key = 4'd0;
        b_start = 1'b0; b_key = 4'd0; b_wr_en = 1'b0; b_wr_level = 1'b0; b_wr_idx = 3'd0; b_wr_key = 4'd0;
        do_reset();

        // Reset state
        check("rst_lives",  32'(a_lives), 32'd3);
        check("rst_level",  32'(a_level), 32'd0);
        check("rst_idx",    32'(a_idx), 32'd0);
        check("rst_timer",  32'(a_timer_left), 32'd0);
        check("rst_busy",   32'(a_busy), 32'd0);
        check("rst_over",   32'(a_game_over), 32'd0);
        check("rst_expkey", 32'(a_expected_key), 32'd15);

        // Level 0 = {3,2}: two matches, level done, reload on level 1
        a_write(2'd0, 3'd0, 4'd3);
        a_write(2'd0, 3'd1, 4'd2);
        check("load_expkey", 32'(a_expected_key), 32'd3);
        a_go();
        check("start_busy",  32'(a_busy), 32'd1);
        check("start_timer", 32'(a_timer_left), 32'd50);
        a_key = 4'd3; tick(1);
        check("m1_match", 32'(a_key_match), 32'd1);
        check("m1_miss",  32'(a_key_miss), 32'd0);
        a_key = 4'd0; tick(1);
        check("m1_idx",   32'(a_idx), 32'd1);
        check("m1_pulse_end", 32'(a_key_match), 32'd0);
        tick(1);
        check("m2_expkey", 32'(a_expected_key), 32'd2);
        a_key = 4'd2; tick(1);
        check("m2_match", 32'(a_key_match), 32'd1);
        a_key = 4'd0; tick(3);
        check("l0_done",  32'(a_level_done), 32'd1);
        tick(1);
        check("l1_level", 32'(a_level), 32'd1);
        check("l1_timer", 32'(a_timer_left), 32'd50);
        check("l1_idx",   32'(a_idx), 32'd0);
        tick(1);
        check("empty_l1_done", 32'(a_level_done), 32'd1);

        // Asynchronous reset mid-game
        reset = 1'b1;
        #1;
        check("areset_busy",  32'(a_busy), 32'd0);
        check("areset_level", 32'(a_level), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Miss: press 3, release, press 5
        a_write(2'd0, 3'd0, 4'd3);
        a_write(2'd0, 3'd1, 4'd2);
        a_go();
        a_key = 4'd3; tick(1);
        a_key = 4'd0; tick(2);
        a_key = 4'd5; tick(1);
        check("miss_pulse", 32'(a_key_miss), 32'd1);
        check("miss_nomatch", 32'(a_key_match), 32'd0);
        tick(1);
        check("miss_idx",   32'(a_idx), 32'd0);
        check("miss_lives", 32'(a_lives), 32'd3);
        check("miss_expkey", 32'(a_expected_key), 32'd3);
        a_key = 4'd0;

        // Timeout with key arriving on the expiry cycle; write while busy
        do_reset();
        a_write(2'd0, 3'd0, 4'd3);
        a_write(2'd0, 3'd1, 4'd2);
        a_go();
        tick(5);
        a_write(2'd0, 3'd0, 4'd7);
        tick(1);
        check("busy_wr_ignored", 32'(a_expected_key), 32'd3);
        tick(43);
        check("to_n50_nolose", 32'(a_lose_life), 32'd0);
        check("to_n50_timer",  32'(a_timer_left), 32'd0);
        a_key = 4'd3; tick(1);
        check("to_lose",    32'(a_lose_life), 32'd1);
        check("to_nomatch", 32'(a_key_match), 32'd0);
        a_key = 4'd0; tick(1);
        check("to_lives", 32'(a_lives), 32'd2);
        check("to_level", 32'(a_level), 32'd0);
        check("to_busy",  32'(a_busy), 32'd1);
        check("to_timer", 32'(a_timer_left), 32'd50);

        // dut_b: single life runs out, restart, then win both levels
        do_reset();
        check("b_rst_lives", 32'(b_lives), 32'd1);
        b_write(1'b0, 3'd0, 4'd1);
        b_write(1'b1, 3'd0, 4'd1);
        b_go();
        tick(20);
        check("b_n20_nolose", 32'(b_lose_life), 32'd0);
        tick(1);
        check("b_lose", 32'(b_lose_life), 32'd1);
        tick(1);
        check("b_over",  32'(b_game_over), 32'd1);
        check("b_nbusy", 32'(b_busy), 32'd0);
        check("b_lives0", 32'(b_lives), 32'd0);
        b_go();
        check("b_restart_lives", 32'(b_lives), 32'd1);
        check("b_restart_level", 32'(b_level), 32'd0);
        check("b_restart_busy",  32'(b_busy), 32'd1);
        check("b_restart_over",  32'(b_game_over), 32'd0);
        b_key = 4'd1; tick(1);
        b_key = 4'd0; tick(3);
        check("b_l0_done", 32'(b_level_done), 32'd1);
        tick(1);
        check("b_l1_level", 32'(b_level), 32'd1);
        b_key = 4'd1; tick(1);
        b_key = 4'd0; tick(3);
        check("b_l1_done", 32'(b_level_done), 32'd1);
        tick(1);
        check("b_won",       32'(b_game_won), 32'd1);
        check("b_won_level", 32'(b_level), 32'd1);
        check("b_won_busy",  32'(b_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
